mode_exit_ctrl: RTL
===================

Name: mode_exit_ctrl

Overview:
- Return path of the mode dispatch. The top-level selector moves DEFAULT -> {STORE, GEN, SHOW, CALC, SETUP} on a debounced button pulse; this block decides when the active mode ends.
- It issues a one-cycle exit request back to the selector, which then returns mode_state to DEFAULT.
- Exit triggers: user exit (button with all switches down), sub-block completion, or inactivity timeout.
- A busy sub-block is drained first, and aborted if it does not finish within a bounded time.

Parameters:
- BUSY_TIMEOUT_CYC, 5_000_000: max cycles to wait for sub_busy to fall after an exit trigger (100 ms at 50 MHz); must be >= 1.
- IDLE_TIMEOUT_CYC, 0: inactivity cycles before auto-exit; 0 disables the idle exit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- btn_pulse  in  1  debounced one-cycle button pulse (same source as the selector)
- mode_sw  in  5  one-hot mode switches
- mode_state  in  3  current mode from the selector (0 = DEFAULT)
- sub_busy  in  1  active sub-block is mid-operation
- sub_done  in  1  one-cycle pulse: active sub-block finished its task
- exit_pulse  out  1  one-cycle request to the selector to return to DEFAULT
- abort_pulse  out  1  one-cycle forced abort to the sub-block (drain timeout)
- exit_reason  out  2  0 NONE, 1 USER, 2 DONE, 3 IDLE; latched at the exit trigger
- active_mode  out  3  mode code latched on entry; 0 when idle
- in_mode  out  1  high whenever the FSM is not in IDLE

Behaviour:
- All outputs are registered.
- Reset values: exit_pulse=0, abort_pulse=0, exit_reason=0, active_mode=0, in_mode=0; FSM=IDLE; both counters cleared.
- States: IDLE, ACTIVE, DRAIN, EXIT, HOLD.
- IDLE:
  - mode_state != 0 -> ACTIVE.
  - On that transition: latch active_mode=mode_state, clear idle counter, clear exit_reason.
- ACTIVE:
  - Triggers in priority order: USER (btn_pulse && mode_sw==5'b00000) > DONE (sub_done) > IDLE (idle counter reaches IDLE_TIMEOUT_CYC-1, only when IDLE_TIMEOUT_CYC != 0).
  - Idle counter increments every cycle. It clears on any btn_pulse and on any cycle where mode_sw differs from its value in the previous cycle.
  - btn_pulse with nonzero mode_sw is not an exit; it only clears the idle counter.
  - Trigger with sub_busy=0 -> EXIT.
  - Trigger with sub_busy=1 -> DRAIN; load the busy timer.
  - exit_reason is latched in the trigger cycle.
- DRAIN:
  - sub_busy=0 -> EXIT.
  - Busy timer reaches BUSY_TIMEOUT_CYC-1 with sub_busy still 1 -> EXIT, with abort_pulse=1 in the same cycle as exit_pulse.
  - btn_pulse, sub_done and idle expiry are ignored.
- EXIT:
  - exit_pulse=1 for exactly this one cycle -> HOLD.
- HOLD:
  - Wait for mode_state==0; then go to IDLE and clear active_mode.
  - No further exit_pulse is issued while in HOLD.
- Latency: trigger sampled at edge N with sub_busy=0 -> exit_pulse high in cycle N+1, low in N+2.
- Boundary cases:
  - mode_state drops to 0 in ACTIVE or DRAIN (external selector reset) -> IDLE next cycle, with no exit_pulse and no abort_pulse.
  - mode_state changes to a different nonzero code in ACTIVE -> re-latch active_mode and clear the idle counter.
  - sub_busy falls in the same cycle the busy timer expires -> clean exit, no abort.
  - rst_n asserted mid-DRAIN -> immediately IDLE; no pulses emitted.
  - The busy timer and idle counter saturate; they never wrap.

Decomposition:
- Shared package holds:
  - mode codes MODE_DEFAULT..MODE_SETUP (0..5), common with the selector;
  - exit reason codes EXIT_NONE/USER/DONE/IDLE;
  - FSM state encoding.
- One sub-module: cycle_timer (load, enable, parameterised terminal count, saturating, expire flag).
  - Instantiated twice: idle timer and busy timer.
  - Counter width is $clog2 of the terminal count.

Test Plan:
1. mode_state 0->1 (STORE), sub_busy=0; mode_sw=0 with btn_pulse at cycle 10 -> exit_pulse high in cycle 11 only; exit_reason=1; active_mode=1 until mode_state returns to 0, then 0.
2. ACTIVE in CALC (4); sub_done pulse with sub_busy=0 -> exit_pulse next cycle; exit_reason=2; abort_pulse stays 0.
3. BUSY_TIMEOUT_CYC=8; user exit while sub_busy=1, sub_busy falls after 3 cycles -> exit_pulse one cycle after the fall; abort_pulse=0.
4. BUSY_TIMEOUT_CYC=8; sub_busy held high -> exit_pulse and abort_pulse both high together, 8 cycles after the trigger.
5. IDLE_TIMEOUT_CYC=16, no inputs after entering SETUP (5) -> exit_pulse at cycle 17 after entry, exit_reason=3. Repeat with a mode_sw toggle at cycle 10 -> exit delayed to cycle 27.
6. Same cycle btn_pulse (mode_sw=0) and sub_done -> exit_reason=1. Separately, rst_n low during DRAIN -> all outputs 0 immediately; no pulses after release.

Source files
------------

// File: rtl/mode_exit_ctrl_pkg.sv
// Encodings shared by the mode selector and its exit controller.
// Mode codes must stay in step with the selector.
package mode_exit_ctrl_pkg;

  typedef enum logic [2:0] {
    MODE_DEFAULT = 3'd0,
    MODE_STORE   = 3'd1,
    MODE_GEN     = 3'd2,
    MODE_SHOW    = 3'd3,
    MODE_CALC    = 3'd4,
    MODE_SETUP   = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    EXIT_NONE = 2'd0,
    EXIT_USER = 2'd1,
    EXIT_DONE = 2'd2,
    EXIT_IDLE = 2'd3
  } exit_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_EXIT   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned SW_W   = 5;

  function automatic int unsigned tmr_w(input int unsigned tc);
    return (tc < 2) ? 1 : $clog2(tc);
  endfunction

endpackage

// File: rtl/mode_exit_ctrl_cycle_timer.sv
// Saturating cycle counter with clear, preload-to-one and expire flag.
// Expire asserts while the count sits at TERM_CNT-1.
module mode_exit_ctrl_cycle_timer
  import mode_exit_ctrl_pkg::*;
#(
  parameter int unsigned TERM_CNT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned W = tmr_w(TERM_CNT);
  localparam logic [W-1:0] LAST = W'(TERM_CNT - 1);
  localparam logic [W-1:0] PRE  =
    (TERM_CNT > 1) ? W'(1) : '0;

  logic [W-1:0] r_cnt;

  // Load counts the loading cycle itself as elapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= PRE;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/mode_exit_ctrl.sv
// Decides when the active mode ends and requests the selector to
// return to DEFAULT, draining or aborting a busy sub-block first.
module mode_exit_ctrl
  import mode_exit_ctrl_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT_CYC = 5_000_000,
  parameter int unsigned IDLE_TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_pulse,
  input  logic [SW_W-1:0]   mode_sw,
  input  logic [MODE_W-1:0] mode_state,
  input  logic              sub_busy,
  input  logic              sub_done,
  output logic              exit_pulse,
  output logic              abort_pulse,
  output logic [1:0]        exit_reason,
  output logic [MODE_W-1:0] active_mode,
  output logic              in_mode
);

  localparam bit IDLE_EN = (IDLE_TIMEOUT_CYC != 0);
  localparam int unsigned IDLE_TC =
    IDLE_EN ? IDLE_TIMEOUT_CYC : 1;

  state_e            r_state;
  state_e            w_next;
  exit_e             r_reason;
  exit_e             w_reason;
  logic [MODE_W-1:0] r_mode;
  logic [SW_W-1:0]   r_sw_prev;
  logic              r_exit;
  logic              r_abort;
  logic              r_in;

  logic w_off;
  logic w_user;
  logic w_act;
  logic w_trig;
  logic w_idle_exp;
  logic w_busy_exp;
  logic w_in_active;

  assign w_in_active = (r_state == ST_ACTIVE);
  assign w_off  = (mode_state == MODE_DEFAULT);
  assign w_user = btn_pulse && (mode_sw == '0);
  assign w_act  = btn_pulse
               || (mode_sw != r_sw_prev)
               || (mode_state != r_mode);

  mode_exit_ctrl_cycle_timer #(
    .TERM_CNT (IDLE_TC)
  ) u_idle_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (!w_in_active || w_act),
    .i_load   (1'b0),
    .i_en     (w_in_active),
    .o_expire (w_idle_exp)
  );

  mode_exit_ctrl_cycle_timer #(
    .TERM_CNT (BUSY_TIMEOUT_CYC)
  ) u_busy_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state == ST_IDLE),
    .i_load   (w_in_active),
    .i_en     (r_state == ST_DRAIN),
    .o_expire (w_busy_exp)
  );

  // Activity in the same cycle wins over an idle expiry.
  always_comb begin
    w_reason = EXIT_NONE;
    if (w_user) begin
      w_reason = EXIT_USER;
    end else if (sub_done) begin
      w_reason = EXIT_DONE;
    end else if (IDLE_EN && w_idle_exp && !w_act) begin
      w_reason = EXIT_IDLE;
    end
  end

  assign w_trig = (w_reason != EXIT_NONE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_off) w_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_off) begin
          w_next = ST_IDLE;
        end else if (w_trig) begin
          w_next = sub_busy ? ST_DRAIN : ST_EXIT;
        end
      end
      ST_DRAIN: begin
        if (w_off) begin
          w_next = ST_IDLE;
        end else if (!sub_busy || w_busy_exp) begin
          w_next = ST_EXIT;
        end
      end
      ST_EXIT: w_next = ST_HOLD;
      ST_HOLD: begin
        if (w_off) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_reason  <= EXIT_NONE;
      r_mode    <= '0;
      r_sw_prev <= '0;
      r_exit    <= 1'b0;
      r_abort   <= 1'b0;
      r_in      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sw_prev <= mode_sw;
      r_exit    <= (w_next == ST_EXIT);
      r_abort   <= (r_state == ST_DRAIN)
                && (w_next == ST_EXIT)
                && sub_busy;
      r_in      <= (w_next != ST_IDLE);
      if (w_next == ST_IDLE) begin
        r_mode <= '0;
      end else if (r_state == ST_IDLE
                || r_state == ST_ACTIVE) begin
        r_mode <= mode_state;
      end
      if (r_state == ST_IDLE && !w_off) begin
        r_reason <= EXIT_NONE;
      end else if (w_in_active && !w_off && w_trig) begin
        r_reason <= w_reason;
      end
    end
  end

  assign exit_pulse  = r_exit;
  assign abort_pulse = r_abort;
  assign exit_reason = r_reason;
  assign active_mode = r_mode;
  assign in_mode     = r_in;

endmodule
